// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-to-decode handshake and head/occupancy bundle
interface decode_queue_if #(
  parameter int XLEN = 64,
  parameter int CW = 3
);
  logic in_valid;
  logic in_ready;
  logic [XLEN-1:0] pc_in;
  logic [31:0] inst_in;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] pc_out;
  logic [31:0] inst_out;
  logic compressed_out;
  logic [CW-1:0] count_out;
  modport master (
    output in_valid, pc_in, inst_in, out_ready,
    input in_ready, out_valid, pc_out, inst_out, compressed_out, count_out
  );
  modport slave (
    input in_valid, pc_in, inst_in, out_ready,
    output in_ready, out_valid, pc_out, inst_out, compressed_out, count_out
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: show-ahead {pc, inst} FIFO between fetch and decode, flushed on redirect
module decode_queue #(
  parameter int XLEN = 64,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic trap_en,
  input logic bj_en,
  decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic flush, full, empty, push, pop;
  always_comb begin
    flush = clear | trap_en | bj_en;
    full = count == CW'(DEPTH);
    empty = count == '0;
    push = q.in_valid & ~full & ~flush;
    pop = ~empty & q.out_ready & ~flush;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
  // storage carries no reset; visibility is governed by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp] <= q.pc_in;
      inst_mem[wp] <= q.inst_in;
    end
  end
  always_comb begin
    q.in_ready = ~full;
    q.out_valid = ~empty;
    q.pc_out = empty ? '0 : pc_mem[rp];
    q.inst_out = empty ? 32'h0000_0013 : inst_mem[rp];
    q.compressed_out = ~empty & (inst_mem[rp][1:0] != 2'b11);
    q.count_out = count;
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed self-checking bench for decode_queue (XLEN=64, DEPTH=4)
module tb_decode_queue;
  logic clk = 0, rst = 1, clear = 0, trap_en = 0, bj_en = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] tbl [4] = '{32'h0041a283, 32'h0081a303, 32'h006283b3, 32'h0071a623};
  decode_queue_if #(.XLEN(64), .CW(3)) q ();
  decode_queue #(.XLEN(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .trap_en(trap_en), .bj_en(bj_en), .q(q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic logic [31:0] sinst(input int k);
    return 32'h0000_0003 | (32'(k) << 8);
  endfunction
  initial begin
    q.in_valid = 0; q.out_ready = 0; q.pc_in = '0; q.inst_in = '0;
    #1;
    chk("rst_count", q.count_out, 0);
    chk("rst_valid", q.out_valid, 0);
    chk("rst_ready", q.in_ready, 1);
    chk("rst_pc", q.pc_out, 0);
    chk("rst_inst", q.inst_out, 32'h13);
    chk("rst_comp", q.compressed_out, 0);
    tick();
    rst = 0;
    tick();
    chk("idle_inst", q.inst_out, 32'h13);
    // fill to full with decode stalled
    q.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      q.pc_in = 64'h100 + 64'(4 * i);
      q.inst_in = tbl[i];
      tick();
      chk("fill_count", q.count_out, 64'(i + 1));
      chk("fill_head", q.inst_out, tbl[0]);
    end
    chk("full_ready", q.in_ready, 0);
    q.pc_in = 64'h110; q.inst_in = 32'hdead_0003;
    tick();
    chk("over_count", q.count_out, 4);
    chk("over_inst", q.inst_out, tbl[0]);
    chk("over_pc", q.pc_out, 64'h100);
    // drain; a pop while full must not raise in_ready
    q.in_valid = 0; q.out_ready = 1;
    chk("full_pop_ready", q.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", q.out_valid, 1);
      chk("drain_inst", q.inst_out, tbl[i]);
      chk("drain_pc", q.pc_out, 64'h100 + 64'(4 * i));
      tick();
    end
    chk("empty_valid", q.out_valid, 0);
    chk("empty_inst", q.inst_out, 32'h13);
    chk("empty_count", q.count_out, 0);
    chk("empty_comp", q.compressed_out, 0);
    chk("empty_pc", q.pc_out, 0);
    // streaming with one entry preloaded, wraps pointers several times
    q.out_ready = 0; q.in_valid = 1;
    q.pc_in = 64'h300; q.inst_in = sinst(0);
    tick();
    q.out_ready = 1;
    for (int k = 1; k <= 20; k++) begin
      q.pc_in = 64'h300 + 64'(4 * k);
      q.inst_in = sinst(k);
      chk("stream_inst", q.inst_out, sinst(k - 1));
      chk("stream_pc", q.pc_out, 64'h300 + 64'(4 * (k - 1)));
      tick();
      chk("stream_count", q.count_out, 1);
    end
    chk("stream_last", q.inst_out, sinst(20));
    q.in_valid = 0;
    tick();
    chk("stream_empty", q.out_valid, 0);
    // compressed flag
    q.out_ready = 0; q.in_valid = 1;
    q.pc_in = 64'h400; q.inst_in = 32'h0000_4501;
    tick();
    chk("rvc_comp", q.compressed_out, 1);
    q.pc_in = 64'h402; q.inst_in = 32'h0041a283;
    tick();
    chk("rvc_head", q.inst_out, 32'h0000_4501);
    q.in_valid = 0; q.out_ready = 1;
    tick();
    chk("rv32_inst", q.inst_out, 32'h0041a283);
    chk("rv32_comp", q.compressed_out, 0);
    tick();
    chk("rvc_drained", q.count_out, 0);
    // flush with concurrent push and pop
    q.out_ready = 0; q.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      q.pc_in = 64'h1a0 + 64'(4 * i);
      q.inst_in = tbl[i];
      tick();
    end
    chk("pre_flush_count", q.count_out, 3);
    bj_en = 1; q.out_ready = 1; q.pc_in = 64'h200; q.inst_in = 32'h0010_0093;
    tick();
    bj_en = 0; q.in_valid = 0; q.out_ready = 0;
    chk("flush_count", q.count_out, 0);
    chk("flush_valid", q.out_valid, 0);
    chk("flush_pc", q.pc_out, 0);
    q.in_valid = 1; q.pc_in = 64'h204; q.inst_in = 32'h00a0_0093;
    tick();
    chk("post_flush_count", q.count_out, 1);
    chk("post_flush_pc", q.pc_out, 64'h204);
    chk("post_flush_inst", q.inst_out, 32'h00a0_0093);
    q.pc_in = 64'h208; q.inst_in = 32'h00b0_0093;
    tick();
    q.in_valid = 0;
    chk("pre_rst_count", q.count_out, 2);
    // asynchronous reset mid-cycle
    #2 rst = 1;
    #1;
    chk("arst_valid", q.out_valid, 0);
    chk("arst_ready", q.in_ready, 1);
    chk("arst_inst", q.inst_out, 32'h13);
    chk("arst_count", q.count_out, 0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_valid", q.out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised instruction queue between the if-id register and the decode stage. Fetched `{pc, inst}` pairs are buffered in a DEPTH-entry FIFO so a decode stall does not stall fetch immediately. The queue is flushed on trap or branch/jump redirect. The head entry is presented with a precomputed compressed flag; when the queue is empty, the head outputs a canonical NOP.

## Interface

Parameters:
- `XLEN`, default 64: width of PC.
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports (clock and reset first):
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `clear` input 1: pipeline clear; flushes the queue.
- `trap_en` input 1: trap redirect; flushes the queue.
- `bj_en` input 1: branch/jump redirect; flushes the queue.
- `in_valid` input 1: fetch presents a valid pair.
- `in_ready` output 1: queue can accept; equals `!full`.
- `pc_in` input XLEN: PC of the incoming instruction.
- `inst_in` input 32: incoming instruction word.
- `out_valid` output 1: head entry valid; equals `!empty`.
- `out_ready` input 1: decode consumes the head (decode drives `!stall`).
- `pc_out` output XLEN: head PC.
- `inst_out` output 32: head instruction.
- `compressed_out` output 1: head instruction is RVC.
- `count_out` output CW: number of occupied entries, 0..DEPTH.

## Operation

- `flush = clear | trap_en | bj_en`.
- `push = in_valid & in_ready & !flush`.
- `pop = out_valid & out_ready & !flush`.
- Storage is a DEPTH-entry array of `{pc, inst}` with write pointer `wp` and read pointer `rp`, each `log2(DEPTH)` bits wide. Pointers wrap naturally modulo DEPTH. The array itself is not reset.
- Push: writes `{pc_in, inst_in}` at `wp`, then `wp += 1`.
- Pop: `rp += 1`.
- Count update:
  - push only: `count += 1`
  - pop only: `count -= 1`
  - both or neither: unchanged.
- Flush has priority over everything. On a flush, `wp`, `rp` and `count` go to 0. A concurrent push and pop are discarded; the fetch word is dropped, not enqueued.
- `full = (count == DEPTH)`; `empty = (count == 0)`.
- `in_ready = !full`. There is no pass-through when full: a pop while full does not raise `in_ready` in the same cycle.
- When not empty, head outputs are `pc_out = mem[rp].pc` and `inst_out = mem[rp].inst` (show-ahead, combinational read of storage).
- When empty: `pc_out = 0`, `inst_out = 32'h00000013` (addi x0,x0,0), `compressed_out = 0`.
- `compressed_out = (inst_out[1:0] != 2'b11)` when not empty.
- `count_out = count`.

## Timing

- Reset (asynchronous, immediate) and after release, until the first push:
  - `count_out = 0`, `out_valid = 0`, `in_ready = 1`
  - `pc_out = 0`, `inst_out = 32'h00000013`, `compressed_out = 0`.
- Latency: a pair pushed at edge N appears on the outputs with `out_valid = 1` right after edge N, i.e. in cycle N+1. There is no same-cycle bypass from input to output.
- A pop at edge N exposes the next entry, or the NOP if the queue is now empty, right after edge N.
- Push and pop in the same cycle are legal when 0 < count < DEPTH. When `count == DEPTH`, only pop occurs; when `count == 0`, only push occurs.
- Flush takes effect at the next edge. Outputs are still driven from pre-flush state during the flush cycle, but `pop` is suppressed so decode must ignore them. The queue is empty from the next cycle onward.
- Reset asserted mid-operation clears pointers and count immediately; stored data becomes invisible.
- Throughput: one push and one pop per cycle sustained.

## Test plan

- Reset, then hold `out_ready = 0`. Push pc 0x100/0x104/0x108/0x10c with insts 0041a283, 0081a303, 006283b3, 0071a623 → `count_out` steps 1..4; `in_ready = 0` after the 4th push; a 5th `in_valid` is not accepted; `inst_out = 0041a283`, `pc_out = 0x100`.
- From full, raise `out_ready` for 4 cycles with `in_valid = 0` → heads appear in order 0041a283, 0081a303, 006283b3, 0071a623, then `out_valid = 0`, `inst_out = 00000013`, `count_out = 0`.
- Continuous `in_valid` and `out_ready` with 1 entry preloaded → count stays 1 for 20 cycles; outputs arrive in order with 1-cycle latency; pointer wrap exercised (> DEPTH transfers).
- Push inst 32'h00004501 (c.li) → `compressed_out = 1`; push 0041a283 → `compressed_out = 0`.
- With 3 entries, assert `bj_en` together with `in_valid` (pc 0x200) and `out_ready` → next cycle `count_out = 0`; pc 0x200 is never output; the next push appears normally.
- Assert `rst` asynchronously mid-cycle with 2 entries → `out_valid` drops and `in_ready` rises before the next clock edge; `inst_out = 00000013`.
